// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Register-file writeback arbiter. Merges ALU and LSU writeback
//            requests round-robin into an in-order FIFO that drives the
//            register file's single write port. It also keeps a per-register
//            pending-write scoreboard that decode uses for hazard checks.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            alu_*_i / alu_ready_o - ALU writeback request channel
//            lsu_*_i / lsu_ready_o - LSU writeback request channel
//            rf_hold_i             - write port unavailable this cycle
//            rf_wen_o/waddr_o/wdata_o - register file write port
//            alloc_valid_i/rd_i    - decode destination allocation
//            busy_vec_o            - per-register pending-write flags
//            fifo_count_o          - FIFO occupancy
//            sb_err_o              - sticky scoreboard over/underflow
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid_i,
  output logic                          alu_ready_o,
  input  logic [ADDR_WIDTH-1:0]         alu_rd_i,
  input  logic [DATA_WIDTH-1:0]         alu_data_i,
  input  logic                          lsu_valid_i,
  output logic                          lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]         lsu_rd_i,
  input  logic [DATA_WIDTH-1:0]         lsu_data_i,
  input  logic                          rf_hold_i,
  output logic                          rf_wen_o,
  output logic [ADDR_WIDTH-1:0]         rf_waddr_o,
  output logic [DATA_WIDTH-1:0]         rf_wdata_o,
  input  logic                          alloc_valid_i,
  input  logic [ADDR_WIDTH-1:0]         alloc_rd_i,
  output logic [2**ADDR_WIDTH-1:0]      busy_vec_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          sb_err_o
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_NREG  = 2**ADDR_WIDTH;

  typedef enum logic {RR_ALU = 1'b0, RR_LSU = 1'b1} rr_e;

  rr_e                    rr_q, rr_d;
  logic [c_PTR_W-1:0]     rptr_q, wptr_q;
  logic [c_CNT_W-1:0]     count_q, count_d;
  logic [ADDR_WIDTH-1:0]  addr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  data_mem [FIFO_DEPTH];
  logic [c_NREG-1:0]      busy_q, busy_d, err_set;
  logic                   sb_err_q;

  logic                   not_empty, pop, push, space, grant, pick_lsu;
  logic [ADDR_WIDTH-1:0]  pick_rd, head_addr;
  logic [DATA_WIDTH-1:0]  pick_data, head_data;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty && !rf_hold_i;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign space     = (count_q < c_CNT_W'(FIFO_DEPTH)) || pop;
  assign head_addr = addr_mem[rptr_q];
  assign head_data = data_mem[rptr_q];

  // Outputs are gated by occupancy, so the async reset of count_q drops
  // rf_wen and clears the address/data without waiting for a clock edge.
  assign rf_wen_o   = pop;
  assign rf_waddr_o = not_empty ? head_addr : '0;
  assign rf_wdata_o = not_empty ? head_data : '0;

  // Arbitration: the round-robin pointer only matters when both channels
  // request; the pointer moves past whichever channel was granted.
  always_comb begin
    pick_lsu = lsu_valid_i;
    if (alu_valid_i && lsu_valid_i) begin
      pick_lsu = (rr_q == RR_LSU);
    end
    pick_rd   = pick_lsu ? lsu_rd_i   : alu_rd_i;
    pick_data = pick_lsu ? lsu_data_i : alu_data_i;
    // rd==0 writes are discarded, so they never need FIFO space.
    grant     = (alu_valid_i || lsu_valid_i) && ((pick_rd == '0) || space);
    push      = grant && (pick_rd != '0);
    alu_ready_o = grant && !pick_lsu;
    lsu_ready_o = grant &&  pick_lsu;
    rr_d = rr_q;
    if (grant) begin
      rr_d = pick_lsu ? RR_ALU : RR_LSU;
    end
    count_d = count_q + c_CNT_W'(push) - c_CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q     <= RR_ALU;
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      sb_err_q <= sb_err_q | (|err_set);
      if (pop)  rptr_q <= rptr_q + c_PTR_W'(1);
      if (push) wptr_q <= wptr_q + c_PTR_W'(1);
    end
  end

  // Storage needs no reset: stale entries are never visible once count_q is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q] <= pick_rd;
      data_mem[wptr_q] <= pick_data;
    end
  end

  // Scoreboard: 2-bit pending-write counter per register, x0 excluded.
  for (genvar r = 0; r < c_NREG; r++) begin : g_sb
    if (r == 0) begin : g_zero
      assign busy_d[r]  = 1'b0;
      assign err_set[r] = 1'b0;
    end else begin : g_reg
      logic       inc, dec, err;
      logic [1:0] cnt_q, cnt_d;

      assign inc = alloc_valid_i && (alloc_rd_i == ADDR_WIDTH'(r));
      assign dec = pop && (head_addr == ADDR_WIDTH'(r));

      always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        if (inc && !dec) begin
          if (cnt_q == 2'd3) err = 1'b1;
          else               cnt_d = cnt_q + 2'd1;
        end else if (dec && !inc) begin
          if (cnt_q == 2'd0) err = 1'b1;
          else               cnt_d = cnt_q - 2'd1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 2'd0;
        else     cnt_q <= cnt_d;
      end

      assign busy_d[r]  = (cnt_d != 2'd0);
      assign err_set[r] = err;
    end
  end

  assign busy_vec_o   = busy_q;
  assign fifo_count_o = count_q;
  assign sb_err_o     = sb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter. A queue-based reference
//            model predicts every output each cycle; directed scenarios are
//            followed by a randomized run with occasional resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, rf_hold, alloc_valid;
  logic [4:0]  alu_rd, lsu_rd, alloc_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, rf_wen, sb_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;
  logic [2:0]  fifo_count;

  wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
    .rf_hold_i(rf_hold), .rf_wen_o(rf_wen), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .alloc_valid_i(alloc_valid), .alloc_rd_i(alloc_rd),
    .busy_vec_o(busy_vec), .fifo_count_o(fifo_count), .sb_err_o(sb_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t m_q[$];
  int   m_cnt[32];
  bit   m_rr_lsu;
  bit   m_err;

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic m_clear();
    m_q.delete();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_rr_lsu = 1'b0;
    m_err    = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check just after, advance the model,
  // then return shortly after the following posedge.
  task automatic do_cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                          input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                          input bit hold, input bit alv, input logic [4:0] alrd);
    bit          pop, space, any, pick_lsu, grant;
    logic [4:0]  prd, exp_addr, dec_r;
    logic [31:0] pdat, exp_data;
    bit          do_inc, do_dec;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    rf_hold = hold; alloc_valid = alv; alloc_rd = alrd;
    #1;
    pop      = (m_q.size() > 0) && !hold;
    space    = (m_q.size() < 4) || pop;
    exp_addr = (m_q.size() > 0) ? m_q[0].a : 5'd0;
    exp_data = (m_q.size() > 0) ? m_q[0].d : 32'd0;
    any      = av || lv;
    pick_lsu = (av && lv) ? m_rr_lsu : lv;
    prd      = pick_lsu ? lrd : ard;
    pdat     = pick_lsu ? ld  : ad;
    grant    = any && ((prd == 5'd0) || space);
    check_eq("alu_ready",  alu_ready,  grant && !pick_lsu);
    check_eq("lsu_ready",  lsu_ready,  grant &&  pick_lsu);
    check_eq("rf_wen",     rf_wen,     pop);
    check_eq("rf_waddr",   rf_waddr,   exp_addr);
    check_eq("rf_wdata",   rf_wdata,   exp_data);
    check_eq("fifo_count", fifo_count, m_q.size());
    check_eq("busy_vec",   busy_vec,   m_busy());
    check_eq("sb_err",     sb_err,     m_err);
    // model update
    do_inc = alv && (alrd != 0);
    dec_r  = exp_addr;
    do_dec = pop && (dec_r != 0);
    if (pop) void'(m_q.pop_front());
    if (grant) begin
      m_rr_lsu = !pick_lsu;
      if (prd != 0) m_q.push_back('{a: prd, d: pdat});
    end
    if (do_inc && do_dec && alrd == dec_r) begin
      // simultaneous allocate and retire of the same register cancel out
    end else begin
      if (do_inc) begin
        if (m_cnt[alrd] == 3) m_err = 1'b1; else m_cnt[alrd]++;
      end
      if (do_dec) begin
        if (m_cnt[dec_r] == 0) m_err = 1'b1; else m_cnt[dec_r]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit hold);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, hold, 0, 0);
  endtask

  // Asserts reset wherever the bench currently is in the cycle and checks
  // that outputs clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    alu_valid = 0; lsu_valid = 0; rf_hold = 0; alloc_valid = 0;
    alu_rd = 0; lsu_rd = 0; alloc_rd = 0; alu_data = 0; lsu_data = 0;
    #1;
    check_eq("rst_wen",   rf_wen,     1'b0);
    check_eq("rst_count", fifo_count, 3'd0);
    check_eq("rst_busy",  busy_vec,   32'd0);
    check_eq("rst_err",   sb_err,     1'b0);
    check_eq("rst_waddr", rf_waddr,   5'd0);
    check_eq("rst_wdata", rf_wdata,   32'd0);
    m_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m_clear();
    do_reset();

    // Single ALU write with a prior allocation of rd=5.
    do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5);
    check_eq("t1_busy5_set", busy_vec[5], 1'b1);
    do_cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    check_eq("t1_count", fifo_count, 3'd1);
    idle(2, 0);
    check_eq("t1_busy5_clr", busy_vec[5], 1'b0);

    // Both channels valid for two cycles: ALU first, then LSU.
    do_reset();
    do_cycle(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0);
    do_cycle(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0);
    idle(2, 0);

    // Hold with five requests: four fit, fifth is refused until a pop.
    for (int i = 1; i <= 5; i++) do_cycle(1, 5'(i), 32'(i * 'h100), 0, 0, 0, 1, 0, 0);
    check_eq("t3_full", fifo_count, 3'd4);
    do_cycle(1, 5, 32'h500, 0, 0, 0, 0, 0, 0);
    check_eq("t3_pushpop", fifo_count, 3'd4);
    idle(5, 0);

    // Full FIFO: LSU push with pop, then rd=0 acknowledged while full.
    for (int i = 1; i <= 4; i++) do_cycle(1, 5'(i + 8), 32'(i), 0, 0, 0, 1, 0, 0);
    do_cycle(0, 0, 0, 1, 9, 32'h99, 0, 0, 0);
    do_cycle(1, 0, 32'hBAD, 0, 0, 0, 1, 0, 0);
    check_eq("t4_rd0_full", fifo_count, 3'd4);
    idle(5, 0);

    // Scoreboard saturation, then allocate and retire rd=7 together.
    do_reset();
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 7);
    check_eq("t5_sb_err", sb_err, 1'b1);
    do_cycle(1, 7, 32'h77, 0, 0, 0, 1, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 7);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t5_busy7", busy_vec[7], 1'b1);

    // Reset with three queued entries while a write is in progress.
    do_reset();
    for (int i = 1; i <= 3; i++) do_cycle(1, 5'(i), 32'(i), 0, 0, 0, 1, 1, 5'(i));
    @(negedge clk);
    rf_hold = 1'b0; alu_valid = 1'b0; alloc_valid = 1'b0;
    #1;
    check_eq("t6_pre_wen",   rf_wen,     1'b1);
    check_eq("t6_pre_count", fifo_count, 3'd3);
    #2;
    do_reset();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk);
        #($urandom_range(1, 4));
        do_reset();
      end else begin
        do_cycle($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                 5'($urandom_range(0, 31)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
